ofb_stream_ctrl: RTL

- Sequential controller that runs a DES block core in OFB mode over a stream of 64-bit blocks.
- Holds key and feedback register, issues one core request per block, XORs keystream with input, registers output.
- OFB encrypt and decrypt are identical, so one block serves both; it replaces bench-driven combinational OFB_enc/OFB_dec chaining.
- Sits between a block source/sink (valid/ready) and an external DES core with start/done handshake.

---
 rtl/ofb_pkg.sv | 22 ++
 rtl/ofb_stream_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/ofb_pkg.sv
// Shared types and constants for the OFB stream controller.
// Holds the FSM state enum, default widths and the DES known-answer vector.
`timescale 1ns/1ps
package ofb_pkg;

    localparam int BLK_W_DEF = 64;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        UNCFG,
        START,
        WAIT,
        HAVE_KS,
        DRAIN
    } ofb_state_t;

    // DES reference vector: E_K(IV) under this key is KAT_CT.
    localparam logic [63:0] KAT_KEY = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KAT_IV  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E8_1354_0F0A_B405;

endpackage

// File: rtl/ofb_stream_ctrl.sv
// OFB-mode stream controller around an external DES block core.
// Keystream = E_K(feedback); each accepted block is XORed with it and registered.
//
// state   | meaning
// UNCFG   | no key/IV loaded, input blocked
// START   | core_start pulse with current feedback/key
// WAIT    | waiting for core_done of the live request
// HAVE_KS | keystream ready, accepting one input block
// DRAIN   | reloaded while a request was in flight; next core_done is dropped
`timescale 1ns/1ps
module ofb_stream_ctrl
    import ofb_pkg::*;
#(
    parameter int BLK_W = BLK_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [BLK_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             core_start,
    output logic [BLK_W-1:0] core_in,
    output logic [BLK_W-1:0] core_key,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_out,
    output logic [CNT_W-1:0] block_cnt,
    output logic             busy
);

    ofb_state_t       state, state_nx;
    logic [BLK_W-1:0] key, feedback, ks;
    logic             ks_valid;
    logic             in_fire;

    assign in_ready = (state == HAVE_KS) && ks_valid && !cfg_load &&
                      (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign core_in  = feedback;
    assign core_key = key;
    assign busy     = (state == START) || (state == WAIT);

    always_comb begin
        state_nx   = state;
        core_start = 1'b0;
        unique case (state)
            UNCFG: begin
                if (cfg_load) state_nx = START;
            end
            START: begin
                core_start = 1'b1;
                state_nx   = cfg_load ? DRAIN : WAIT;
            end
            WAIT: begin
                // A done arriving with the reload retires the stale request itself.
                if (cfg_load)       state_nx = core_done ? START : DRAIN;
                else if (core_done) state_nx = HAVE_KS;
            end
            HAVE_KS: begin
                if (cfg_load || in_fire) state_nx = START;
            end
            DRAIN: begin
                if (core_done) state_nx = START;
            end
            default: state_nx = UNCFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UNCFG;
            key       <= '0;
            feedback  <= '0;
            ks        <= '0;
            ks_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            block_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cfg_load) begin
                key       <= cfg_key;
                feedback  <= cfg_iv;
                ks_valid  <= 1'b0;
                block_cnt <= '0;
            end else begin
                if ((state == WAIT) && core_done) begin
                    ks       <= core_out;
                    feedback <= core_out;
                    ks_valid <= 1'b1;
                end
                if (in_fire) begin
                    ks_valid  <= 1'b0;
                    block_cnt <= block_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            // Output register is independent of reloads; pending data waits for the sink.
            if (in_fire) begin
                out_data  <= in_data ^ ks;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
